// File: rtl/serial_rx.sv
// UART receive side for SCON modes 1-3: 16x oversampled, 2-of-3 majority per bit,
// SM2 multiprocessor load rule, RI set on load and cleared by software pulse.
module serial_rx #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       serial_rx_clk_i,
    input  logic       serial_rx_reset_i,
    input  logic       serial_rx_tick16_i,
    input  logic       serial_rx_rxd_i,
    input  logic       serial_rx_sm0_i,
    input  logic       serial_rx_sm1_i,
    input  logic       serial_rx_sm2_i,
    input  logic       serial_rx_ren_i,
    input  logic       serial_rx_ri_clr_i,
    output logic [7:0] serial_rx_sbuf_o,
    output logic       serial_rx_rb8_o,
    output logic       serial_rx_ri_o,
    output logic       serial_rx_busy_o,
    output logic       serial_rx_lost_o
);

    // state | meaning
    // IDLE  | waiting for a low RXD on a tick (REN=1, mode != 0)
    // START | start bit, rejected as a false start if it votes high
    // DATA  | eight data bits, LSB first
    // BIT9  | ninth bit (modes 2/3), load decision here
    // STOP  | stop bit; mode 1 decides the load here, modes 2/3 just finish
    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] START = 3'd1;
    localparam logic [2:0] DATA  = 3'd2;
    localparam logic [2:0] BIT9  = 3'd3;
    localparam logic [2:0] STOP  = 3'd4;

    logic [SYNC_STAGES-1:0] sync;
    logic                   rxd_s;
    logic [2:0]             state;
    logic [3:0]             t;
    logic [3:0]             b;
    logic [1:0]             mode;
    logic [7:0]             shift;
    logic                   s7;
    logic                   s8;
    logic                   maj;
    logic                   decide;
    logic                   check;
    logic                   load;
    logic [7:0]             sbuf;
    logic                   rb8;
    logic                   ri;
    logic                   lost;

    assign rxd_s  = sync[SYNC_STAGES-1];
    assign maj    = (s7 & s8) | (s7 & rxd_s) | (s8 & rxd_s);
    assign decide = serial_rx_tick16_i && (t == 4'd9) && (state != IDLE);

    // The last-bit decision is the only point that can load or discard a frame.
    assign check = serial_rx_ren_i && decide &&
                   ((state == BIT9) || ((state == STOP) && (mode == 2'b01)));
    assign load  = check && !ri && (!serial_rx_sm2_i || maj);

    always_ff @(posedge serial_rx_clk_i) begin
        if (serial_rx_reset_i) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], serial_rx_rxd_i};
        end
    end

    always_ff @(posedge serial_rx_clk_i) begin
        if (serial_rx_reset_i) begin
            state <= IDLE;
            t     <= 4'd0;
            b     <= 4'd0;
            mode  <= 2'b00;
            shift <= 8'h00;
            s7    <= 1'b1;
            s8    <= 1'b1;
        end else if ((state != IDLE) && !serial_rx_ren_i) begin
            state <= IDLE;
            t     <= 4'd0;
            b     <= 4'd0;
        end else if (serial_rx_tick16_i) begin
            if (state == IDLE) begin
                if (serial_rx_ren_i && ({serial_rx_sm0_i, serial_rx_sm1_i} != 2'b00) && !rxd_s) begin
                    // the detect tick is t=0, so the next tick is t=1
                    state <= START;
                    mode  <= {serial_rx_sm0_i, serial_rx_sm1_i};
                    t     <= 4'd1;
                    b     <= 4'd0;
                end
            end else begin
                t <= t + 4'd1;
                if (t == 4'd7) s7 <= rxd_s;
                if (t == 4'd8) s8 <= rxd_s;
                if (t == 4'd15) b <= b + 4'd1;
                case (state)
                    START: begin
                        if ((t == 4'd9) && maj) begin
                            state <= IDLE;
                            t     <= 4'd0;
                        end else if (t == 4'd15) begin
                            state <= DATA;
                        end
                    end
                    DATA: begin
                        if (t == 4'd9) shift <= {maj, shift[7:1]};
                        if ((t == 4'd15) && (b == 4'd8)) state <= (mode == 2'b01) ? STOP : BIT9;
                    end
                    BIT9: begin
                        if (t == 4'd15) state <= STOP;
                    end
                    STOP: begin
                        if (t == 4'd9) begin
                            state <= IDLE;
                            t     <= 4'd0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    // A load beats a coincident RI clear; a clear on a discarded frame still clears.
    always_ff @(posedge serial_rx_clk_i) begin
        if (serial_rx_reset_i) begin
            sbuf <= 8'h00;
            rb8  <= 1'b0;
            ri   <= 1'b0;
            lost <= 1'b0;
        end else begin
            lost <= check && !load;
            if (load) begin
                sbuf <= shift;
                rb8  <= maj;
                ri   <= 1'b1;
            end else if (serial_rx_ri_clr_i) begin
                ri <= 1'b0;
            end
        end
    end

    assign serial_rx_sbuf_o = sbuf;
    assign serial_rx_rb8_o  = rb8;
    assign serial_rx_ri_o   = ri;
    assign serial_rx_busy_o = (state != IDLE);
    assign serial_rx_lost_o = lost;

endmodule

// File: tb/tb_serial_rx.sv
// Directed frames for serial_rx; expected load/lost events go into a queue that
// a negedge monitor drains whenever RI rises or LOST pulses.
module tb_serial_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick = 1'b0;
    logic       rxd = 1'b1;
    logic       sm0 = 1'b0;
    logic       sm1 = 1'b1;
    logic       sm2 = 1'b0;
    logic       ren = 1'b0;
    logic       ri_clr = 1'b0;
    logic [7:0] sbuf;
    logic       rb8;
    logic       ri;
    logic       busy;
    logic       lost;

    int checks = 0;
    int fails = 0;
    int tick_no = 0;
    int frame_k = 0;
    int busy_seen = 0;

    typedef struct {
        int         kind;   // 1 = load, 2 = lost
        int         at;
        logic [7:0] sbuf;
        logic       rb8;
        logic       ri;
        logic       busy;
    } exp_t;

    exp_t sb[$];

    serial_rx #(.SYNC_STAGES(2)) dut (
        .serial_rx_clk_i    (clk),
        .serial_rx_reset_i  (rst),
        .serial_rx_tick16_i (tick),
        .serial_rx_rxd_i    (rxd),
        .serial_rx_sm0_i    (sm0),
        .serial_rx_sm1_i    (sm1),
        .serial_rx_sm2_i    (sm2),
        .serial_rx_ren_i    (ren),
        .serial_rx_ri_clr_i (ri_clr),
        .serial_rx_sbuf_o   (sbuf),
        .serial_rx_rb8_o    (rb8),
        .serial_rx_ri_o     (ri),
        .serial_rx_busy_o   (busy),
        .serial_rx_lost_o   (lost)
    );

    always #5 clk = ~clk;

    // one tick every 4 clocks
    initial begin
        int ph;
        ph = 0;
        forever begin
            @(negedge clk);
            ph = (ph + 1) % 4;
            tick = (ph == 0);
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            if (tick) tick_no = tick_no + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    initial begin
        logic ri_prev;
        exp_t e;
        ri_prev = 1'b0;
        forever begin
            @(negedge clk);
            if ((ri && !ri_prev) || lost) begin
                if (sb.size() == 0) begin
                    check("event_expected", 32'(sb.size()), 32'd1);
                end else begin
                    e = sb.pop_front();
                    check("event_kind", (ri && !ri_prev) ? 32'd1 : 32'd2, 32'(e.kind));
                    check("event_tick", 32'(tick_no), 32'(e.at));
                    check("event_sbuf", 32'(sbuf), 32'(e.sbuf));
                    check("event_rb8", 32'(rb8), 32'(e.rb8));
                    check("event_ri", 32'(ri), 32'(e.ri));
                    check("event_busy", 32'(busy), 32'(e.busy));
                end
            end
            ri_prev = ri;
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic sync_tick();
        int s;
        s = tick_no;
        while (tick_no == s) @(negedge clk);
    endtask

    task automatic wait_tick_no(input int n);
        while (tick_no < n) @(negedge clk);
    endtask

    // Bit i is driven just after tick k+16i, so the DUT detects at tick k+1
    // and the load/lost decision lands on tick k+154.
    task automatic send_frame(input logic [8:0] d, input logic nine, input int kind,
                              input logic [7:0] es, input logic erb8, input logic eri,
                              input logic ebusy);
        logic [10:0] bits;
        int nb;
        exp_t e;
        sync_tick();
        frame_k = tick_no;
        if (kind != 0) begin
            e.kind = kind;
            e.at   = frame_k + 154;
            e.sbuf = es;
            e.rb8  = erb8;
            e.ri   = eri;
            e.busy = ebusy;
            sb.push_back(e);
        end
        nb   = nine ? 11 : 10;
        bits = nine ? {1'b1, d, 1'b0} : {2'b11, d[7:0], 1'b0};
        for (int i = 0; i < nb; i++) begin
            rxd = bits[i];
            repeat (16) sync_tick();
        end
        rxd = 1'b1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_sbuf"}, 32'(sbuf), 32'h00);
        check({tag, "_rb8"}, 32'(rb8), 32'd0);
        check({tag, "_ri"}, 32'(ri), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_lost"}, 32'(lost), 32'd0);
    endtask

    initial begin
        repeat (5) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_values("reset");

        // mode 1, SM2=0
        sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0; ren = 1'b1;
        repeat (8) @(negedge clk);
        send_frame(9'h0A5, 1'b0, 1, 8'hA5, 1'b1, 1'b1, 1'b0);
        ri_clr = 1'b1;
        @(negedge clk);
        ri_clr = 1'b0;
        check("ri_clear", 32'(ri), 32'd0);

        // mode 3, SM2=1: 9th bit 0 is dropped, 9th bit 1 loads
        sm0 = 1'b1; sm1 = 1'b1; sm2 = 1'b1;
        send_frame(9'h03C, 1'b1, 2, 8'hA5, 1'b1, 1'b0, 1'b1);
        fork
            send_frame(9'h15A, 1'b1, 1, 8'h5A, 1'b1, 1'b1, 1'b1);
            begin
                wait (rxd == 1'b0);
                wait_tick_no(frame_k + 169);
                check("m3_busy_tick168", 32'(busy), 32'd1);
                wait_tick_no(frame_k + 170);
                check("m3_busy_tick169", 32'(busy), 32'd0);
            end
        join

        // overrun with RI set, then RI clear on the exact decision cycle
        sm0 = 1'b0; sm1 = 1'b1; sm2 = 1'b0;
        send_frame(9'h011, 1'b0, 2, 8'h5A, 1'b1, 1'b1, 1'b0);
        fork
            send_frame(9'h022, 1'b0, 2, 8'h5A, 1'b1, 1'b0, 1'b0);
            begin
                wait (rxd == 1'b0);
                wait_tick_no(frame_k + 153);
                repeat (3) @(negedge clk);
                ri_clr = 1'b1;
                @(negedge clk);
                ri_clr = 1'b0;
            end
        join

        // false start: 5-tick low glitch
        sync_tick();
        frame_k = tick_no;
        check("fs_busy_before", 32'(busy), 32'd0);
        rxd = 1'b0;
        sync_tick();
        check("fs_busy_detect", 32'(busy), 32'd1);
        repeat (4) sync_tick();
        rxd = 1'b1;
        wait_tick_no(frame_k + 9);
        check("fs_busy_tick8", 32'(busy), 32'd1);
        wait_tick_no(frame_k + 10);
        check("fs_busy_tick9", 32'(busy), 32'd0);
        check("fs_sbuf", 32'(sbuf), 32'h5A);
        check("fs_ri", 32'(ri), 32'd0);
        repeat (8) sync_tick();

        // REN dropped in the middle of data bit 4
        fork
            send_frame(9'h077, 1'b0, 0, 8'h00, 1'b0, 1'b0, 1'b0);
            begin
                wait (rxd == 1'b0);
                wait_tick_no(frame_k + 69);
                check("abort_busy_before", 32'(busy), 32'd1);
                ren = 1'b0;
                @(negedge clk);
                check("abort_busy_after", 32'(busy), 32'd0);
            end
        join
        check("abort_ri", 32'(ri), 32'd0);
        ren = 1'b1;

        // mode 0 never starts
        sm0 = 1'b0; sm1 = 1'b0;
        busy_seen = 0;
        for (int i = 0; i < 160; i++) begin
            @(negedge clk);
            if (i % 8 == 0) rxd = ~rxd;
            if (busy) busy_seen++;
        end
        rxd = 1'b1;
        check("mode0_busy", 32'(busy_seen), 32'd0);
        repeat (8) sync_tick();

        // reset in the middle of data bit 6, then a clean mode 2 frame
        sm0 = 1'b1; sm1 = 1'b0; sm2 = 1'b0;
        fork
            send_frame(9'h1F0, 1'b1, 0, 8'h00, 1'b0, 1'b0, 1'b0);
            begin
                wait (rxd == 1'b0);
                wait_tick_no(frame_k + 101);
                check("midrst_busy_before", 32'(busy), 32'd1);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                check_reset_values("midrst");
            end
        join
        send_frame(9'h1FF, 1'b1, 1, 8'hFF, 1'b1, 1'b1, 1'b1);

        for (int i = 0; i < 200 && sb.size() != 0; i++) @(negedge clk);
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
